// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the ALU issue controller.
package alu_pkg;

    localparam logic [3:0] OP_ADD     = 4'd0;
    localparam logic [3:0] OP_SUB     = 4'd1;
    localparam logic [3:0] OP_MUL     = 4'd2;
    localparam logic [3:0] OP_DIV     = 4'd3;
    localparam logic [3:0] OP_MOD     = 4'd4;
    localparam logic [3:0] OP_LSR     = 4'd5;
    localparam logic [3:0] OP_LSL     = 4'd6;
    localparam logic [3:0] OP_RSR     = 4'd7;
    localparam logic [3:0] OP_RSL     = 4'd8;
    localparam logic [3:0] OP_AND     = 4'd9;
    localparam logic [3:0] OP_OR      = 4'd10;
    localparam logic [3:0] OP_XOR     = 4'd11;
    localparam logic [3:0] OP_NOT     = 4'd12;
    localparam logic [3:0] OP_CMP     = 4'd13;
    localparam logic [3:0] OP_TST     = 4'd14;
    localparam logic [3:0] OP_ILLEGAL = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/alu_issue_timer.sv
// WAIT-phase cycle counter: saturating CW-bit count with a timeout-hit flag.
module alu_issue_timer #(
    parameter int unsigned CW      = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] cycles_c,
    output logic          hit_c
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // cycles_c is the count including the current cycle, held at all-ones once saturated
    always_comb begin
        cycles_c = (count_q == {CW{1'b1}}) ? count_q : count_q + CW'(1);
        count_d  = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = cycles_c;
        end
    end

    assign hit_c = (count_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage in front of the ALU Control_Unit: accept op, launch, wait for finish
// (or time out), then hold the response until it is consumed.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned W       = 16,
    parameter int unsigned OPW     = 4,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CW      = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [OPW-1:0] req_op,
    input  logic [W-1:0]   req_a,
    input  logic [W-1:0]   req_b,
    output logic [OPW-1:0] cu_s,
    output logic           cu_start,
    input  logic           cu_finish,
    output logic [W-1:0]   alu_opa,
    output logic [W-1:0]   alu_opb,
    input  logic [W-1:0]   alu_result,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [W-1:0]   rsp_data,
    output logic           rsp_err,
    output logic [CW-1:0]  rsp_cycles,
    output logic           busy
);

    state_e         state_q, state_d;
    logic [OPW-1:0] cu_s_q, cu_s_d;
    logic [W-1:0]   alu_opa_q, alu_opa_d;
    logic [W-1:0]   alu_opb_q, alu_opb_d;
    logic           cu_start_q, cu_start_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [W-1:0]   rsp_data_q, rsp_data_d;
    logic           rsp_err_q, rsp_err_d;
    logic [CW-1:0]  rsp_cycles_q, rsp_cycles_d;
    logic           busy_q, busy_d;
    logic [CW-1:0]  timer_cycles_c;
    logic           timer_hit_c;

    alu_issue_timer #(
        .CW      (CW),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_q == ST_LAUNCH),
        .enable   (state_q == ST_WAIT),
        .cycles_c (timer_cycles_c),
        .hit_c    (timer_hit_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        cu_s_d       = cu_s_q;
        alu_opa_d    = alu_opa_q;
        alu_opb_d    = alu_opb_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        rsp_cycles_d = rsp_cycles_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_op == OPW'(OP_ILLEGAL)) begin
                        state_d      = ST_RESP;
                        rsp_data_d   = '0;
                        rsp_err_d    = 1'b1;
                        rsp_cycles_d = '0;
                    end else begin
                        state_d   = ST_LAUNCH;
                        cu_s_d    = req_op;
                        alu_opa_d = req_a;
                        alu_opb_d = req_b;
                    end
                end
            end
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT: begin
                // finish takes priority over a timeout landing in the same cycle
                if (cu_finish) begin
                    state_d      = ST_RESP;
                    rsp_data_d   = alu_result;
                    rsp_err_d    = 1'b0;
                    rsp_cycles_d = timer_cycles_c;
                end else if (timer_hit_c) begin
                    state_d      = ST_RESP;
                    rsp_data_d   = '0;
                    rsp_err_d    = 1'b1;
                    rsp_cycles_d = timer_cycles_c;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_d == ST_IDLE) || (state_d == ST_RESP)) begin
            cu_s_d    = '0;
            alu_opa_d = '0;
            alu_opb_d = '0;
        end

        cu_start_d  = (state_d == ST_LAUNCH);
        rsp_valid_d = (state_d == ST_RESP);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cu_s_q       <= '0;
            alu_opa_q    <= '0;
            alu_opb_q    <= '0;
            cu_start_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            rsp_cycles_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cu_s_q       <= cu_s_d;
            alu_opa_q    <= alu_opa_d;
            alu_opb_q    <= alu_opb_d;
            cu_start_q   <= cu_start_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            rsp_cycles_q <= rsp_cycles_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready  = ~rst & (state_q == ST_IDLE);
    assign cu_s       = cu_s_q;
    assign alu_opa    = alu_opa_q;
    assign alu_opb    = alu_opb_q;
    assign cu_start   = cu_start_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_cycles = rsp_cycles_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural Control_Unit/ALU model.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int unsigned W       = 16;
    localparam int unsigned OPW     = 4;
    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned CW      = 8;
    localparam int          NEVER   = 1000;

    logic           clk;
    logic           rst;
    logic           req_valid;
    logic           req_ready;
    logic [OPW-1:0] req_op;
    logic [W-1:0]   req_a;
    logic [W-1:0]   req_b;
    logic [OPW-1:0] cu_s;
    logic           cu_start;
    logic           cu_finish;
    logic [W-1:0]   alu_opa;
    logic [W-1:0]   alu_opb;
    logic [W-1:0]   alu_result;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_data;
    logic           rsp_err;
    logic [CW-1:0]  rsp_cycles;
    logic           busy;

    alu_issue_ctrl #(.W(W), .OPW(OPW), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .cu_s       (cu_s),
        .cu_start   (cu_start),
        .cu_finish  (cu_finish),
        .alu_opa    (alu_opa),
        .alu_opb    (alu_opb),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .rsp_cycles (rsp_cycles),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        err;
        logic [7:0]  cycles;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        int          d;
    } cu_t;

    exp_t exp_q[$];
    cu_t  cu_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   stall_next = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Datapath behaviour the Control_Unit model returns for each opcode
    function automatic logic [15:0] alu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] t;
        int s;
        s = int'(b[3:0]);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  begin t = 32'(a) * 32'(b); return t[15:0]; end
            4'd3:  return (b == 16'd0) ? 16'hffff : a / b;
            4'd4:  return (b == 16'd0) ? a : a % b;
            4'd5:  return a >> s;
            4'd6:  return a << s;
            4'd7:  begin t = {a, a} >> s; return t[15:0]; end
            4'd8:  begin t = {a, a} << s; return t[31:16]; end
            4'd9:  return a & b;
            4'd10: return a | b;
            4'd11: return a ^ b;
            4'd12: return ~a;
            4'd13: return (a < b) ? 16'd1 : 16'd0;
            4'd14: return ((a & b) != 16'd0) ? 16'd1 : 16'd0;
            default: return 16'd0;
        endcase
    endfunction

    // Control_Unit model: finish on the d-th WAIT cycle, never if d exceeds TIMEOUT
    initial begin : cu_model
        cu_t cur;
        int  wcnt;
        bit  pending;
        pending    = 1'b0;
        wcnt       = 0;
        cur        = '{op: 4'd0, a: 16'd0, b: 16'd0, d: 0};
        cu_finish  = 1'b0;
        alu_result = 16'd0;
        forever begin
            @(negedge clk);
            cu_finish  = 1'b0;
            alu_result = 16'($urandom);
            if (rst) begin
                pending = 1'b0;
            end else if (pending) begin
                wcnt++;
                if (wcnt == 1) check("cu_start_one_cycle", 32'(cu_start), 32'd0);
                check("cu_s_hold", 32'(cu_s), 32'(cur.op));
                check("alu_opa_hold", 32'(alu_opa), 32'(cur.a));
                check("alu_opb_hold", 32'(alu_opb), 32'(cur.b));
                if (wcnt == cur.d) begin
                    cu_finish  = 1'b1;
                    alu_result = alu_ref(cur.op, cur.a, cur.b);
                    pending    = 1'b0;
                end else if (wcnt >= int'(TIMEOUT)) begin
                    pending = 1'b0;
                end
            end else begin
                if (cu_start) begin
                    if (cu_q.size() == 0) begin
                        fail_now("spurious_cu_start");
                    end else begin
                        cur     = cu_q.pop_front();
                        pending = 1'b1;
                        wcnt    = 0;
                    end
                end
                // stray finish outside WAIT must be ignored
                if ($urandom_range(0, 7) == 0) cu_finish = 1'b1;
            end
        end
    end

    // Response monitor: random backpressure, stability while stalled, scoreboard pop on handshake
    initial begin : rsp_monitor
        logic [15:0] p_data;
        logic        p_err;
        logic [7:0]  p_cycles;
        bit          have_prev;
        exp_t        e;
        rsp_ready = 1'b0;
        have_prev = 1'b0;
        p_data = 16'd0; p_err = 1'b0; p_cycles = 8'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rsp_ready = 1'b0;
                have_prev = 1'b0;
            end else begin
                if (rsp_valid && stall_next > 0) begin
                    rsp_ready = 1'b0;
                    stall_next--;
                end else begin
                    rsp_ready = ($urandom_range(0, 99) < 60);
                end
                if (rsp_valid) begin
                    check("req_ready_low_in_resp", 32'(req_ready), 32'd0);
                    if (have_prev) begin
                        check("rsp_data_stable", 32'(rsp_data), 32'(p_data));
                        check("rsp_err_stable", 32'(rsp_err), 32'(p_err));
                        check("rsp_cycles_stable", 32'(rsp_cycles), 32'(p_cycles));
                    end
                    p_data = rsp_data; p_err = rsp_err; p_cycles = rsp_cycles;
                    have_prev = 1'b1;
                    if (rsp_ready) begin
                        have_prev = 1'b0;
                        if (exp_q.size() == 0) begin
                            fail_now("unexpected_rsp");
                        end else begin
                            e = exp_q.pop_front();
                            check("rsp_data", 32'(rsp_data), 32'(e.data));
                            check("rsp_err", 32'(rsp_err), 32'(e.err));
                            check("rsp_cycles", 32'(rsp_cycles), 32'(e.cycles));
                        end
                    end
                end else begin
                    have_prev = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input int d);
        int   waited;
        exp_t e;
        bit   legal;
        waited = 0;
        legal  = (op != 4'd15);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        while (!req_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            fail_now("req_accept_timeout");
            req_valid = 1'b0;
            return;
        end
        if (!legal)              e = '{data: 16'd0, err: 1'b1, cycles: 8'd0};
        else if (d <= int'(TIMEOUT)) e = '{data: alu_ref(op, a, b), err: 1'b0, cycles: 8'(d)};
        else                     e = '{data: 16'd0, err: 1'b1, cycles: 8'(TIMEOUT)};
        exp_q.push_back(e);
        if (legal) cu_q.push_back('{op: op, a: a, b: b, d: d});
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 4'($urandom);
        req_a     = 16'($urandom);
        req_b     = 16'($urandom);
        check("cu_start_after_accept", 32'(cu_start), 32'(legal));
        check("busy_after_accept", 32'(busy), 32'd1);
        if (legal) begin
            check("cu_s_launch", 32'(cu_s), 32'(op));
            check("alu_opa_launch", 32'(alu_opa), 32'(a));
            check("alu_opb_launch", 32'(alu_opb), 32'(b));
        end else begin
            check("illegal_rsp_valid_next", 32'(rsp_valid), 32'd1);
        end
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while ((exp_q.size() != 0 || busy) && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0 || busy) fail_now("drain_timeout");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cu_s"}, 32'(cu_s), 32'd0);
        check({tag, "_cu_start"}, 32'(cu_start), 32'd0);
        check({tag, "_alu_opa"}, 32'(alu_opa), 32'd0);
        check({tag, "_alu_opb"}, 32'(alu_opb), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        check({tag, "_rsp_cycles"}, 32'(rsp_cycles), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    endtask

    initial begin : stimulus
        int r;
        int d;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 4'd0;
        req_a     = 16'd0;
        req_b     = 16'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("req_ready_after_reset", 32'(req_ready), 32'd1);
        check("busy_after_reset", 32'(busy), 32'd0);

        issue(OP_ADD, 16'd3, 16'd5, 6);
        drain();
        issue(OP_ILLEGAL, 16'h1234, 16'h5678, 0);
        drain();
        issue(OP_MUL, 16'd300, 16'd7, NEVER);
        drain();
        issue(OP_XOR, 16'h00ff, 16'h0f0f, 3);
        drain();

        // response held off for five cycles while a second request waits
        stall_next = 5;
        issue(OP_OR, 16'h00f0, 16'h0a0a, 2);
        issue(OP_AND, 16'hffff, 16'h1234, 4);
        drain();

        // reset in the middle of WAIT discards the in-flight DIV
        issue(OP_DIV, 16'd100, 16'd7, NEVER);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("midreset");
        exp_q.delete();
        cu_q.delete();
        rst = 1'b0;
        issue(OP_SUB, 16'd10, 16'd4, 2);
        drain();

        // finish lands on the timeout cycle
        issue(OP_LSL, 16'h0013, 16'd4, int'(TIMEOUT));
        drain();

        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6)       d = int'($urandom_range(1, 8));
            else if (r < 8)  d = int'($urandom_range(TIMEOUT - 4, TIMEOUT));
            else if (r == 8) d = NEVER;
            else             d = int'($urandom_range(9, 40));
            issue(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), d);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "global timeout");
    end

endmodule
